// File: rtl/pulse_scheduler.sv
// pulse_scheduler: round-robin arbiter in front of a single clock divider.
// The winning requester's period and burst length are captured when it is
// picked. The divider then emits `count` pulses of period 2*(ticks>>1) on
// `out`, and the burst closes with a one-cycle done (and err) pulse.
//
// state  | meaning
// IDLE   | no owner; arbitrate among req starting at rr_q
// LOAD   | winner granted, latched config checked for validity
// RUN    | divider active, out toggles every half period
// FINISH | one cycle: done/err pulse, rr pointer advances
module pulse_scheduler #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int CW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*N-1:0]  ticks_in,
  input  logic [NREQ*CW-1:0] count_in,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic               out,
  output logic [NREQ-1:0]    done,
  output logic               err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, FINISH = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] gidx_q, gidx_d, rr_q, rr_d, win_idx;
  logic [N-1:0]  ticks_q, ticks_d, cnt_q, cnt_d, win_ticks, half_m1;
  logic [CW-1:0] count_q, count_d, pcnt_q, pcnt_d, win_count;
  logic          out_q, out_d, err_q, err_d;
  logic          any_req, arb_found, bad_cfg, at_half, last_fall, req_held;

  assign any_req   = |req;
  // Odd periods truncate: half = ticks>>1, toggle when the counter hits half-1.
  assign half_m1   = (ticks_q >> 1) - N'(1);
  assign at_half   = (cnt_q == half_m1);
  // Only the falling toggle closes a pulse; the last one ends the burst.
  assign last_fall = at_half && out_q && ((pcnt_q + CW'(1)) == count_q);
  assign bad_cfg   = (ticks_q < N'(2)) || (count_q == '0);
  assign req_held  = req[gidx_q];

  // Round-robin pick: first requester at or after rr_q, wrapping, plus its config.
  always_comb begin
    win_idx   = '0;
    win_ticks = '0;
    win_count = '0;
    arb_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!arb_found && req[(int'(rr_q) + k) % NREQ]) begin
        arb_found = 1'b1;
        win_idx   = IW'((int'(rr_q) + k) % NREQ);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_ticks = ticks_in[i*N +: N];
        win_count = count_in[i*CW +: CW];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = LOAD;
      LOAD:    state_d = bad_cfg ? FINISH : RUN;
      RUN:     if (!req_held || last_fall) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: captured config, divider, pulse counter, err flag.
  always_comb begin
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    ticks_d = ticks_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    out_d   = out_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gidx_d  = win_idx;
          ticks_d = win_ticks;
          count_d = win_count;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        cnt_d  = '0;
        pcnt_d = '0;
        out_d  = 1'b0;
        if (bad_cfg) err_d = 1'b1;
      end
      RUN: begin
        if (!req_held) begin
          out_d = 1'b0;
          err_d = 1'b1;
        end else if (at_half) begin
          out_d = ~out_q;
          cnt_d = '0;
          if (out_q) pcnt_d = pcnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q + N'(1);
        end
      end
      FINISH: begin
        out_d  = 1'b0;
        cnt_d  = '0;
        pcnt_d = '0;
        rr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gidx_q  <= '0;
      rr_q    <= '0;
      ticks_q <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      ticks_q <= ticks_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from state; grant is held from LOAD through FINISH.
  always_comb begin
    busy = (state_q != IDLE);
    out  = (state_q == RUN) && out_q;
    err  = (state_q == FINISH) && err_q;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = busy && (gidx_q == IW'(i));
      done[i]  = (state_q == FINISH) && (gidx_q == IW'(i));
    end
  end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: reset, round-robin order, a table of
// single-requester bursts, abort on req drop, and reset mid-burst.
module tb_pulse_scheduler;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int CW   = 16;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*N-1:0]  ticks_in;
  logic [NREQ*CW-1:0] count_in;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic               out_s;
  logic [NREQ-1:0]    done;
  logic               err;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_scheduler #(.N(N), .NREQ(NREQ), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .ticks_in (ticks_in),
    .count_in (count_in),
    .grant    (grant),
    .busy     (busy),
    .out      (out_s),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int ticks;
    int count;
    int exp_run;   // RUN cycles between LOAD and FINISH
    int exp_high;  // cycles with out high
    int exp_rise;  // RUN cycle index of first out high, -1 if none
    int exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run, high, rise, falls, steps;
    logic prev, seen;

    vecs[0] = '{0, 4, 3, 12, 6, 2, 0};
    vecs[1] = '{1, 5, 2, 8, 4, 2, 0};
    vecs[2] = '{2, 1, 5, 0, 0, -1, 1};
    vecs[3] = '{2, 6, 0, 0, 0, -1, 1};
    vecs[4] = '{3, 2, 3, 6, 3, 1, 0};
    vecs[5] = '{0, 3, 1, 2, 1, 1, 0};
    vecs[6] = '{1, 7, 1, 6, 3, 3, 0};
    vecs[7] = '{3, 0, 1, 0, 0, -1, 1};
    vecs[8] = '{2, 2, 1, 2, 1, 1, 0};

    rst = 1'b0; req = '0; ticks_in = '0; count_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_out", out_s, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    step();

    // Round robin: all four request, ticks=2 count=1 each.
    for (int i = 0; i < NREQ; i++) begin
      ticks_in[i*N +: N]   = 2;
      count_in[i*CW +: CW] = 1;
    end
    req = 4'hF;
    for (int k = 0; k < NREQ; k++) begin
      step();
      check("rr_grant", grant, 32'(1) << k);
      step();
      step();
      step();
      check("rr_done", done, 32'(1) << k);
      check("rr_err", err, 0);
      if (k == NREQ - 1) req = 4'b0011;
      step();
      check("rr_idle_busy", busy, 0);
    end
    step();
    check("rr_wrap_grant", grant, 4'b0001);
    req = '0;
    step();
    step();
    check("rr_abort_done", done, 4'b0001);
    check("rr_abort_err", err, 1);
    check("rr_abort_out", out_s, 0);
    step();
    check("rr_abort_idle", busy, 0);

    // Table of single-requester bursts.
    for (int v = 0; v < 9; v++) begin
      ticks_in = '0;
      count_in = '0;
      ticks_in[vecs[v].idx*N +: N]   = N'(vecs[v].ticks);
      count_in[vecs[v].idx*CW +: CW] = CW'(vecs[v].count);
      req = 4'(1 << vecs[v].idx);
      step();
      check("vec_load_grant", grant, 32'(1) << vecs[v].idx);
      check("vec_load_busy", busy, 1);
      check("vec_load_out", out_s, 0);
      // Captured config must survive input changes after LOAD.
      ticks_in = '1;
      count_in = '1;
      run = 0; high = 0; rise = -1; seen = 1'b0;
      for (int t = 0; t < 400; t++) begin
        step();
        if (done != 0) begin
          seen = 1'b1;
          break;
        end
        if (out_s) begin
          high++;
          if (rise < 0) rise = run;
        end
        run++;
      end
      check("vec_done_seen", seen, 1);
      check("vec_run_cycles", run, vecs[v].exp_run);
      check("vec_high_cycles", high, vecs[v].exp_high);
      check("vec_first_rise", rise, vecs[v].exp_rise);
      check("vec_done", done, 32'(1) << vecs[v].idx);
      check("vec_err", err, vecs[v].exp_err);
      check("vec_fin_out", out_s, 0);
      check("vec_fin_grant", grant, 32'(1) << vecs[v].idx);
      req = '0;
      step();
      check("vec_idle_busy", busy, 0);
      check("vec_idle_grant", grant, 0);
    end

    // Abort: ticks=8 count=10, drop req while the third pulse is high.
    ticks_in = '0;
    count_in = '0;
    ticks_in[0 +: N]   = 8;
    count_in[0 +: CW]  = 10;
    req = 4'b0001;
    step();
    falls = 0; prev = 1'b0; steps = 0;
    for (int t = 0; t < 200; t++) begin
      step();
      steps++;
      if (prev && !out_s) falls++;
      prev = out_s;
      if (falls == 2 && out_s) break;
    end
    check("abort_cycle", steps, 21);
    check("abort_out_high", out_s, 1);
    req = '0;
    step();
    check("abort_out", out_s, 0);
    check("abort_done", done, 4'b0001);
    check("abort_err", err, 1);
    check("abort_grant", grant, 4'b0001);
    step();
    check("abort_idle", busy, 0);

    // Reset mid-burst.
    ticks_in[1*N +: N]   = 4;
    count_in[1*CW +: CW] = 5;
    req = 4'b0010;
    step();
    repeat (5) step();
    check("mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out", out_s, 0);
    step();
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    rst = 1'b1;
    step();
    check("mid_resume_grant", grant, 4'b0010);
    req = '0;
    step();
    step();
    step();
    check("mid_resume_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
